// File: rtl/ram1_uart_ctrl.sv
// Shared RAM1 data-bus sequencer for SRAM and UART accesses from the MEM stage.
// Optional macro RAM1_UART_TX_WAIT_EN adds a TX-complete wait after UART writes.
module ram1_uart_ctrl #(
    parameter int          SRAM_CYC       = 2,
    parameter int          WRN_CYC        = 2,
    parameter int          RDN_CYC        = 2,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [17:0] Ram1Addr_o,
    inout  wire  [15:0] Ram1Data_io,
    output logic        Ram1OE_o,
    output logic        Ram1WE_o,
    output logic        Ram1EN_o,
    output logic        wrn_o,
    output logic        rdn_o,
    input  logic        data_ready_i,
    input  logic        tbre_i,
    input  logic        tsre_i
);

    localparam int CW = 8;
    localparam logic [CW-1:0] SRAM_RELOAD = CW'(SRAM_CYC - 1);
    localparam logic [CW-1:0] WRN_RELOAD  = CW'(WRN_CYC - 1);
    localparam logic [CW-1:0] RDN_RELOAD  = CW'(RDN_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        SR,
        SW,
        UR,
        UW,
        UW_HOLD,
        STAT,
`ifdef RAM1_UART_TX_WAIT_EN
        TX_TBRE,
        TX_TSRE,
`endif
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [17:0]   addr_q, addr_d;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          oe_q, oe_d;
    logic          we_q, we_d;
    logic          en_q, en_d;
    logic          wrn_q, wrn_d;
    logic          rdn_q, rdn_d;
    logic          drive_q, drive_d;

    logic dr_s, tbre_s, tsre_s;
    assign dr_s   = sync2_q[2];
    assign tbre_s = sync2_q[1];
    assign tsre_s = sync2_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        sync1_d = {data_ready_i, tbre_i, tsre_i};
        sync2_d = sync1_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_i) begin
                    wdata_d = wdata_i;
                    if (addr_i == UART_STAT_ADDR) begin
                        state_d = STAT;
                    end else if (addr_i == UART_DATA_ADDR) begin
                        state_d = we_i ? UW : UR;
                        cnt_d   = we_i ? WRN_RELOAD : RDN_RELOAD;
                    end else begin
                        state_d = we_i ? SW : SR;
                        cnt_d   = SRAM_RELOAD;
                        addr_d  = {2'b00, addr_i};
                    end
                end
            end
            SR: begin
                if (cnt_q == '0) begin
                    rdata_d = Ram1Data_io;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SW: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            UR: begin
                if (cnt_q == '0) begin
                    rdata_d = {8'h00, Ram1Data_io[7:0]};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            UW: begin
                if (cnt_q == '0) state_d = UW_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
`ifdef RAM1_UART_TX_WAIT_EN
            UW_HOLD: state_d = TX_TBRE;
            TX_TBRE: if (tbre_s) state_d = TX_TSRE;
            TX_TSRE: if (tsre_s) state_d = DONE;
`else
            UW_HOLD: state_d = DONE;
`endif
            STAT: begin
                rdata_d = {14'b0, dr_s, tbre_s & tsre_s};
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they change on the same edge as the state.
        busy_d  = !(state_d == IDLE || state_d == DONE);
        done_d  = (state_d == DONE);
        en_d    = !(state_d == SR || state_d == SW);
        oe_d    = !(state_d == SR);
        we_d    = !(state_d == SW && cnt_d != '0);
        rdn_d   = !(state_d == UR);
        wrn_d   = !(state_d == UW);
        drive_d = (state_d == SW || state_d == UW || state_d == UW_HOLD);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            en_q    <= 1'b1;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            en_q    <= en_d;
            wrn_q   <= wrn_d;
            rdn_q   <= rdn_d;
            drive_q <= drive_d;
        end
    end

    assign Ram1Data_io = drive_q ? wdata_q : 16'hzzzz;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign Ram1Addr_o  = addr_q;
    assign Ram1OE_o    = oe_q;
    assign Ram1WE_o    = we_q;
    assign Ram1EN_o    = en_q;
    assign wrn_o       = wrn_q;
    assign rdn_o       = rdn_q;

endmodule

// File: tb/tb_ram1_uart_ctrl.sv
// Directed bench for ram1_uart_ctrl with a small SRAM and UART bus model on the shared data bus.
module tb_ram1_uart_ctrl;

   logic        CLK;
   logic        RST;
   logic        req_i;
   logic        we_i;
   logic [15:0] addr_i;
   logic [15:0] wdata_i;
   logic [15:0] rdata_o;
   logic        busy_o;
   logic        done_o;
   logic [17:0] Ram1Addr_o;
   wire  [15:0] Ram1Data;
   logic        Ram1OE_o;
   logic        Ram1WE_o;
   logic        Ram1EN_o;
   logic        wrn_o;
   logic        rdn_o;
   logic        data_ready_i;
   logic        tbre_i;
   logic        tsre_i;

   int checkCount = 0;
   int passCount  = 0;
   int overlapErr = 0;

   int          lat, weLow, oeLow, enLow, rdnLow, wrnLow, holdOk, busDrv, busyGap;
   logic [17:0] addrAtDone;

`ifdef RAM1_UART_TX_WAIT_EN
   localparam int UW_LAT = 13;
`else
   localparam int UW_LAT = 4;
`endif

   ram1_uart_ctrl dut (
      .CLK          (CLK),
      .RST          (RST),
      .req_i        (req_i),
      .we_i         (we_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .Ram1Addr_o   (Ram1Addr_o),
      .Ram1Data_io  (Ram1Data),
      .Ram1OE_o     (Ram1OE_o),
      .Ram1WE_o     (Ram1WE_o),
      .Ram1EN_o     (Ram1EN_o),
      .wrn_o        (wrn_o),
      .rdn_o        (rdn_o),
      .data_ready_i (data_ready_i),
      .tbre_i       (tbre_i),
      .tsre_i       (tsre_i)
   );

   // Free-running 100 MHz clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // SRAM and UART models: they drive the bus only while the DUT strobes ask them to
   logic        modelOn = 1'b0;
   logic [15:0] mem [0:255];
   logic [15:0] uartVal = 16'hAB5A;
   logic        sramRd, uartRd;
   assign sramRd   = modelOn && !Ram1EN_o && !Ram1OE_o && Ram1WE_o;
   assign uartRd   = modelOn && !rdn_o;
   assign Ram1Data = sramRd ? mem[Ram1Addr_o[7:0]] : (uartRd ? uartVal : 16'hzzzz);

   // SRAM latches the bus on the rising edge of its write strobe
   always @(posedge Ram1WE_o) begin
      if (modelOn && !Ram1EN_o) mem[Ram1Addr_o[7:0]] <= Ram1Data;
   end

   // Watch for strobe pairs that must never be low together
   always @(negedge CLK) begin
      if (!RST && ((!Ram1OE_o && !Ram1WE_o) || (!rdn_o && !wrn_o))) overlapErr <= overlapErr + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   // Issue one access, then watch each cycle until done_o, tallying strobe activity
   task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d, input int budget);
      logic prevWe;
      @(negedge CLK);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      @(posedge CLK);
      #1 req_i = 1'b0;
      lat = 99; weLow = 0; oeLow = 0; enLow = 0; rdnLow = 0; wrnLow = 0;
      holdOk = 0; busDrv = 0; busyGap = 0; addrAtDone = '1;
      prevWe = 1'b1;
      for (int n = 1; n <= budget; n++) begin
         @(negedge CLK);
         if (done_o) begin
            lat = n;
            addrAtDone = Ram1Addr_o;
            break;
         end
         if (!Ram1WE_o) weLow++;
         if (!Ram1OE_o) oeLow++;
         if (!Ram1EN_o) enLow++;
         if (!rdn_o) rdnLow++;
         if (!wrn_o) wrnLow++;
         if (!busy_o) busyGap++;
         if (Ram1WE_o && !prevWe && !Ram1EN_o && Ram1Data == d) holdOk++;
         if ((!Ram1WE_o || !wrn_o) && Ram1Data == d) busDrv++;
         prevWe = Ram1WE_o;
      end
   endtask

   initial begin
      RST = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
      data_ready_i = 1'b0; tbre_i = 1'b0; tsre_i = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

      // Reset values
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_strobes", {Ram1OE_o, Ram1WE_o, Ram1EN_o, wrn_o, rdn_o, busy_o, done_o}, 7'b1111100);
      checkOutput("rst_addr", Ram1Addr_o, 18'h00000);
      checkOutput("rst_rdata", rdata_o, 16'h0000);
      RST = 1'b0;
      modelOn = 1'b1;
      repeat (2) @(negedge CLK);

      // SRAM write
      applyStimulus(1'b1, 16'h4000, 16'h1234, 20);
      checkOutput("sw_lat", lat, 3);
      checkOutput("sw_addr", addrAtDone, 18'h04000);
      checkOutput("sw_we_low", weLow, 1);
      checkOutput("sw_en_low", enLow, 2);
      checkOutput("sw_hold", holdOk, 1);
      checkOutput("sw_bus", busDrv, 1);
      checkOutput("sw_rdata_kept", rdata_o, 16'h0000);

      // SRAM read of the same address
      applyStimulus(1'b0, 16'h4000, 16'h0000, 20);
      checkOutput("sr_lat", lat, 3);
      checkOutput("sr_addr", addrAtDone, 18'h04000);
      checkOutput("sr_oe_low", oeLow, 2);
      checkOutput("sr_we_low", weLow, 0);
      checkOutput("sr_rdata", rdata_o, 16'h1234);

      // UART data read
      applyStimulus(1'b0, 16'hBF00, 16'h0000, 20);
      checkOutput("ur_lat", lat, 3);
      checkOutput("ur_rdn_low", rdnLow, 2);
      checkOutput("ur_en_low", enLow, 0);
      checkOutput("ur_rdata", rdata_o, 16'h005A);

      // Status reads with the UART status lines settled through the synchronizer
      @(negedge CLK);
      data_ready_i = 1'b1; tbre_i = 1'b1; tsre_i = 1'b0;
      repeat (3) @(negedge CLK);
      applyStimulus(1'b0, 16'hBF01, 16'h0000, 20);
      checkOutput("stat_lat", lat, 2);
      checkOutput("stat_rdata_a", rdata_o, 16'h0002);
      tsre_i = 1'b1;
      repeat (3) @(negedge CLK);
      applyStimulus(1'b0, 16'hBF01, 16'h0000, 20);
      checkOutput("stat_rdata_b", rdata_o, 16'h0003);

      // UART write; TX status rises some cycles after the write strobe releases
      data_ready_i = 1'b0; tbre_i = 1'b0; tsre_i = 1'b0;
      repeat (3) @(negedge CLK);
      fork
         begin
            @(posedge wrn_o);
            repeat (5) @(negedge CLK);
            tbre_i = 1'b1;
            repeat (3) @(negedge CLK);
            tsre_i = 1'b1;
         end
      join_none
      applyStimulus(1'b1, 16'hBF00, 16'h0041, 40);
      checkOutput("uw_lat", lat, UW_LAT);
      checkOutput("uw_wrn_low", wrnLow, 2);
      checkOutput("uw_bus", busDrv, 2);
      checkOutput("uw_busy", busyGap, 0);
      checkOutput("uw_en_low", enLow, 0);
      checkOutput("uw_rdata_kept", rdata_o, 16'h0003);
      repeat (12) @(negedge CLK);

      // Back-to-back: inputs wander while busy, new read presented in the DONE cycle
      @(negedge CLK);
      req_i = 1'b1; we_i = 1'b1; addr_i = 16'h0123; wdata_i = 16'hBEEF;
      @(posedge CLK);
      #1;
      req_i = 1'b0; we_i = 1'b0; addr_i = 16'h0999; wdata_i = 16'h7777;
      lat = 99; addrAtDone = '1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge CLK);
         if (done_o) begin
            lat = n;
            addrAtDone = Ram1Addr_o;
            break;
         end
         req_i = 1'b1;
      end
      checkOutput("b2b_first_lat", lat, 3);
      checkOutput("b2b_first_addr", addrAtDone, 18'h00123);
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0123; wdata_i = 16'h0000;
      @(posedge CLK);
      #1 req_i = 1'b0;
      @(negedge CLK);
      checkOutput("b2b_no_idle", {busy_o, done_o}, 2'b10);
      lat = 99;
      for (int n = 2; n <= 10; n++) begin
         @(negedge CLK);
         if (done_o) begin
            lat = n;
            break;
         end
      end
      checkOutput("b2b_second_lat", lat, 3);
      checkOutput("b2b_rdata", rdata_o, 16'hBEEF);

      // Asynchronous reset in the middle of an SRAM write
      @(negedge CLK);
      req_i = 1'b1; we_i = 1'b1; addr_i = 16'h4000; wdata_i = 16'h5555;
      @(posedge CLK);
      #1 req_i = 1'b0;
      @(negedge CLK);
      checkOutput("mid_sw_we", Ram1WE_o, 1'b0);
      #2 RST = 1'b1;
      #1;
      checkOutput("mid_rst_async", {Ram1WE_o, Ram1EN_o, busy_o}, 3'b110);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("post_rst_idle", {busy_o, done_o}, 2'b00);
      applyStimulus(1'b0, 16'hBF01, 16'h0000, 20);
      checkOutput("post_rst_stat_lat", lat, 2);

      checkOutput("strobe_overlap", overlapErr, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
